// File: rtl/rv_core_pkg.sv
// Shared core constants and helpers for the register-file writeback path.
// XLEN and REG_ADDR_W set the default data and address widths of the
// writeback arbiter; REG_ZERO is the hard-wired zero register (x0).
package rv_core_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;

   // Population count of a request vector of up to eight sources.
   function automatic int unsigned popcount8(input logic [7:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: scans req upward from ptr (modulo N)
// and returns a one-hot grant plus the index of the winner. Produces an
// all-zero grant when no request bit is set.
module rr_priority_pick #(
   parameter int N     = 3,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             any_o
);

   // First requester at or after ptr wins; later matches are masked by any_o.
   always_comb begin
      int j;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!any_o && req_i[j]) begin
            any_o      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NUM_REQ writeback sources. Grant is combinational in the request cycle;
// the winning write appears on wr_en/wr_addr/wr_data one cycle later.
// A grant to x0 consumes the request but suppresses wr_en.
// Optional feature macro WB_FWD_EN: adds rs1/rs2 forwarding of the write
// currently being committed (wr_en/wr_addr/wr_data).
module regfile_wb_arbiter
   import rv_core_pkg::*;
#(
   parameter  int NUM_REQ    = 3,
   parameter  int DATA_WIDTH = XLEN,
   parameter  int NUM_REGS   = 1 << REG_ADDR_W,
   localparam int ADDR_W     = $clog2(NUM_REGS),
   localparam int CNT_W      = $clog2(NUM_REQ + 1),
   localparam int PTR_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          async_reset,
   input  logic                          wb_stall,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_rd,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            grant,
`ifdef WB_FWD_EN
   input  logic [ADDR_W-1:0]             rs1_addr,
   input  logic [ADDR_W-1:0]             rs2_addr,
   output logic                          rs1_fwd_hit,
   output logic                          rs2_fwd_hit,
   output logic [DATA_WIDTH-1:0]         rs1_fwd_data,
   output logic [DATA_WIDTH-1:0]         rs2_fwd_data,
`endif
   output logic                          wr_en,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [DATA_WIDTH-1:0]         wr_data,
   output logic [CNT_W-1:0]              busy_cnt
);

   logic [NUM_REQ-1:0]    req_elig;
   logic [NUM_REQ-1:0]    pick_grant;
   logic [PTR_W-1:0]      pick_idx;
   logic                  pick_any;
   logic [ADDR_W-1:0]     sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;

   logic [PTR_W-1:0]      rr_ptr_q,   rr_ptr_d;
   logic                  wr_en_q,    wr_en_d;
   logic [ADDR_W-1:0]     wr_addr_q,  wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q,  wr_data_d;
   logic [CNT_W-1:0]      busy_cnt_q, busy_cnt_d;

   // Stall and reset both block arbitration so no grant leaks out.
   assign req_elig = (async_reset || wb_stall) ? '0 : req;

   rr_priority_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i   (req_elig),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   assign grant    = pick_grant;
   assign sel_rd   = req_rd[int'(pick_idx)*ADDR_W +: ADDR_W];
   assign sel_data = req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];

   // Next-state: pointer advance past the winner, write capture, lost-request count.
   always_comb begin
      int unsigned pending;
      rr_ptr_d  = rr_ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (pick_any) begin
         rr_ptr_d  = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + PTR_W'(1);
         wr_en_d   = (sel_rd != ADDR_W'(REG_ZERO));
         wr_addr_d = sel_rd;
         wr_data_d = sel_data;
      end
      pending = popcount8(8'(req));
      if (pending == 0) begin
         busy_cnt_d = '0;
      end else begin
         busy_cnt_d = CNT_W'(pending - int'(pick_any));
      end
   end

   // State registers; every field clears on reset so no stale write survives it.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         rr_ptr_q   <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_cnt_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy_cnt = busy_cnt_q;

`ifdef WB_FWD_EN
   // The committing write is visible to readers in the same cycle; x0 never forwards.
   assign rs1_fwd_hit  = wr_en_q & (wr_addr_q == rs1_addr) & (rs1_addr != '0);
   assign rs2_fwd_hit  = wr_en_q & (wr_addr_q == rs2_addr) & (rs2_addr != '0);
   assign rs1_fwd_data = wr_data_q;
   assign rs2_fwd_data = wr_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (NUM_REQ=3, 32-bit data, 32 regs).
// The driver pushes each expected grant with its write into a queue; a
// negedge monitor pops on every DUT grant and checks the registered write
// one cycle later. Forwarding checks build only with WB_FWD_EN.
module tb_regfile_wb_arbiter;

   typedef struct packed {
      logic [2:0]  g;
      logic        en;
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;

   logic        clk;
   logic        async_reset;
   logic        wb_stall;
   logic [2:0]  req;
   logic [14:0] req_rd;
   logic [95:0] req_data;
   logic [2:0]  grant;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  busy_cnt;
`ifdef WB_FWD_EN
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        rs1_fwd_hit;
   logic        rs2_fwd_hit;
   logic [31:0] rs1_fwd_data;
   logic [31:0] rs2_fwd_data;
`endif

   int   n_tests;
   int   n_fail;
   exp_t exp_q[$];
   exp_t mon_e;
   exp_t pend;
   logic pend_v;

   regfile_wb_arbiter #(
      .NUM_REQ    (3),
      .DATA_WIDTH (32),
      .NUM_REGS   (32)
   ) dut (
      .clk          (clk),
      .async_reset  (async_reset),
      .wb_stall     (wb_stall),
      .req          (req),
      .req_rd       (req_rd),
      .req_data     (req_data),
      .grant        (grant),
`ifdef WB_FWD_EN
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_fwd_hit  (rs1_fwd_hit),
      .rs2_fwd_hit  (rs2_fwd_hit),
      .rs1_fwd_data (rs1_fwd_data),
      .rs2_fwd_data (rs2_fwd_data),
`endif
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy_cnt     (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic src(input int i, input logic [4:0] rd, input logic [31:0] d);
      req_rd[i*5 +: 5]    = rd;
      req_data[i*32 +: 32] = d;
   endtask

   task automatic push(input logic [2:0] g, input logic en, input logic [4:0] a,
                       input logic [31:0] d);
      exp_t e;
      e.g = g;
      e.en = en;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Monitor: pops one expectation per observed grant and checks its write a cycle later.
   always @(negedge clk) begin
      if (async_reset) begin
         pend_v = 1'b0;
         chk("grant_in_reset", 64'(grant), 64'd0);
      end else begin
         if (pend_v) begin
            chk("wr_en", 64'(wr_en), 64'(pend.en));
            chk("wr_addr", 64'(wr_addr), 64'(pend.a));
            chk("wr_data", 64'(wr_data), 64'(pend.d));
         end else begin
            chk("wr_en_idle", 64'(wr_en), 64'd0);
         end
         pend_v = 1'b0;
         if (grant != 3'b000) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_grant", 64'(grant), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("grant", 64'(grant), 64'(mon_e.g));
               pend   = mon_e;
               pend_v = 1'b1;
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      pend_v      = 1'b0;
      pend        = '0;
      mon_e       = '0;
      async_reset = 1'b1;
      wb_stall    = 1'b0;
      req         = 3'b111;
      req_rd      = '0;
      req_data    = '0;
`ifdef WB_FWD_EN
      rs1_addr    = 5'd0;
      rs2_addr    = 5'd0;
`endif
      src(0, 5'd1, 32'h0000_0001);
      src(1, 5'd2, 32'h0000_0002);
      src(2, 5'd3, 32'h0000_0003);

      // Reset state with all sources requesting
      #3;
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_busy", 64'(busy_cnt), 64'd0);

      // Stall: req=101 held two cycles, nothing granted, both counted busy
      cyc();
      async_reset = 1'b0;
      wb_stall    = 1'b1;
      req         = 3'b101;
      src(0, 5'd3, 32'hA0A0_0003);
      src(2, 5'd4, 32'hC2C2_0004);
      cyc();
      chk("stall_busy1", 64'(busy_cnt), 64'd2);
      cyc();
      chk("stall_busy2", 64'(busy_cnt), 64'd2);
      wb_stall = 1'b0;
      push(3'b001, 1'b1, 5'd3, 32'hA0A0_0003);
      cyc();
      chk("post_stall_busy", 64'(busy_cnt), 64'd1);
      req = 3'b100;
      push(3'b100, 1'b1, 5'd4, 32'hC2C2_0004);
      cyc();
      chk("single_busy", 64'(busy_cnt), 64'd0);

      // Round robin: req=111 held, rd=5,6,7
      src(0, 5'd5, 32'h1111_0005);
      src(1, 5'd6, 32'h2222_0006);
      src(2, 5'd7, 32'h3333_0007);
      req = 3'b111;
      push(3'b001, 1'b1, 5'd5, 32'h1111_0005);
      push(3'b010, 1'b1, 5'd6, 32'h2222_0006);
      push(3'b100, 1'b1, 5'd7, 32'h3333_0007);
      push(3'b001, 1'b1, 5'd5, 32'h1111_0005);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rr_busy", 64'(busy_cnt), 64'd2);
      end
      cyc();
      chk("rr_busy", 64'(busy_cnt), 64'd2);
      push(3'b010, 1'b1, 5'd6, 32'h2222_0006);

      // Reset mid-cycle with req=111 and a write in flight
      cyc();
      chk("pre_rst_wr_en", 64'(wr_en), 64'd1);
      #1;
      async_reset = 1'b1;
      #1;
      chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
      chk("mid_rst_busy", 64'(busy_cnt), 64'd0);
      chk("mid_rst_grant", 64'(grant), 64'd0);
      chk("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("mid_rst_wr_data", 64'(wr_data), 64'd0);
      push(3'b001, 1'b1, 5'd5, 32'h1111_0005);
      cyc();
      async_reset = 1'b0;

      // x0 write from src1 only; idle sources carry unknown rd/data
      cyc();
      req = 3'b010;
      src(0, 5'bx, 32'bx);
      src(1, 5'd0, 32'hDEAD_BEEF);
      src(2, 5'bx, 32'bx);
      push(3'b010, 1'b0, 5'd0, 32'hDEAD_BEEF);
      cyc();
      req = 3'b000;
      chk("x0_busy", 64'(busy_cnt), 64'd0);

      // Wrap from rr_ptr=2 with req=011; src1 holds its write until granted
      cyc();
      src(0, 5'd10, 32'hAAAA_000A);
      src(1, 5'd11, 32'hBBBB_000B);
      src(2, 5'd0, 32'h0);
      req = 3'b011;
      push(3'b001, 1'b1, 5'd10, 32'hAAAA_000A);
      cyc();
      chk("wrap_busy", 64'(busy_cnt), 64'd1);
      req = 3'b010;
      push(3'b010, 1'b1, 5'd11, 32'hBBBB_000B);
      cyc();
      chk("held_busy", 64'(busy_cnt), 64'd0);

      // Write to x9 for the forwarding check
      req = 3'b001;
      src(0, 5'd9, 32'h9999_CAFE);
      push(3'b001, 1'b1, 5'd9, 32'h9999_CAFE);
      cyc();
      req = 3'b000;
      chk("x9_busy", 64'(busy_cnt), 64'd0);
`ifdef WB_FWD_EN
      rs1_addr = 5'd9;
      rs2_addr = 5'd0;
      #1;
      chk("rs1_fwd_hit", 64'(rs1_fwd_hit), 64'd1);
      chk("rs1_fwd_data", 64'(rs1_fwd_data), 64'h9999_CAFE);
      chk("rs2_fwd_hit", 64'(rs2_fwd_hit), 64'd0);
`endif

      cyc();
      cyc();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
